// File: rtl/io_bus_arbiter_if.sv
// IO bus request/response bundle shared by the WB, EX and external sides of the arbiter.
interface io_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WID_W  = 2
);
  logic              taskValid;
  logic [ADDR_W-1:0] address;
  logic              rwCtrl;
  logic [WID_W-1:0]  widthCtr;
  logic [DATA_W-1:0] writeBus;
  logic              taskReady;
  logic              taskError;
  logic [DATA_W-1:0] readBus;

  modport master (
    output taskValid, address, rwCtrl, widthCtr, writeBus,
    input  taskReady, taskError, readBus
  );

  modport slave (
    input  taskValid, address, rwCtrl, widthCtr, writeBus,
    output taskReady, taskError, readBus
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Locked-grant arbiter sharing the external IO bus between WB (fixed priority) and EX,
// with a one-cycle cooldown after each transaction and a no-response watchdog.
module io_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WID_W   = 2,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  io_bus_arbiter_if.slave  wb,
  io_bus_arbiter_if.slave  ex,
  io_bus_arbiter_if.master ext,
  output logic             owner,
  output logic             busy,
  output logic             timeout_evt
);

  typedef enum logic [1:0] {IDLE, GNT_WB, GNT_EX, COOL} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              req_valid, req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [WID_W-1:0]  req_wid;
  logic [DATA_W-1:0] req_wdata;
  logic              fwd_valid, rsp_ready, rsp_error;
  logic [DATA_W-1:0] rsp_data;
  logic              bus_resp, wd_fire;

  assign busy     = (state == GNT_WB) || (state == GNT_EX);
  assign bus_resp = ext.taskReady | ext.taskError;
  assign wd_fire  = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_comb begin
    req_valid = 1'b0;
    req_addr  = '0;
    req_rw    = 1'b0;
    req_wid   = '0;
    req_wdata = '0;
    if (state == GNT_WB) begin
      req_valid = wb.taskValid;
      req_addr  = wb.address;
      req_rw    = wb.rwCtrl;
      req_wid   = wb.widthCtr;
      req_wdata = wb.writeBus;
    end else if (state == GNT_EX) begin
      req_valid = ex.taskValid;
      req_addr  = ex.address;
      req_rw    = ex.rwCtrl;
      req_wid   = ex.widthCtr;
      req_wdata = ex.writeBus;
    end
  end

  // A real bus response takes precedence over the watchdog in the same cycle.
  always_comb begin
    state_nxt   = state;
    fwd_valid   = 1'b0;
    rsp_ready   = 1'b0;
    rsp_error   = 1'b0;
    rsp_data    = '0;
    timeout_evt = 1'b0;
    case (state)
      IDLE: begin
        if (wb.taskValid)      state_nxt = GNT_WB;
        else if (ex.taskValid) state_nxt = GNT_EX;
      end
      GNT_WB, GNT_EX: begin
        if (!req_valid) begin
          state_nxt = IDLE;
        end else if (bus_resp) begin
          fwd_valid = 1'b1;
          rsp_ready = ext.taskReady;
          rsp_error = ext.taskError;
          rsp_data  = ext.readBus;
          state_nxt = COOL;
        end else if (wd_fire) begin
          rsp_error   = 1'b1;
          timeout_evt = 1'b1;
          state_nxt   = COOL;
        end else begin
          fwd_valid = 1'b1;
          rsp_data  = ext.readBus;
        end
      end
      COOL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ext.taskValid = fwd_valid;
  assign ext.address   = req_addr;
  assign ext.rwCtrl    = req_rw;
  assign ext.widthCtr  = req_wid;
  assign ext.writeBus  = req_wdata;

  assign wb.taskReady = (state == GNT_WB) & rsp_ready;
  assign wb.taskError = (state == GNT_WB) & rsp_error;
  assign wb.readBus   = (state == GNT_WB) ? rsp_data : '0;
  assign ex.taskReady = (state == GNT_EX) & rsp_ready;
  assign ex.taskError = (state == GNT_EX) & rsp_error;
  assign ex.readBus   = (state == GNT_EX) ? rsp_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        cnt <= '0;
        if (wb.taskValid)      owner <= 1'b1;
        else if (ex.taskValid) owner <= 1'b0;
      end else if (busy && !bus_resp) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: cycle-level transaction model compared every cycle,
// plus hand-computed checks at key cycles of each scenario.
module tb_io_bus_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WW  = 2;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic owner, busy, timeout_evt;
  always #5 clk = ~clk;

  io_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .WID_W(WW)) wb_bus ();
  io_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .WID_W(WW)) ex_bus ();
  io_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .WID_W(WW)) ext_bus ();

  io_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WID_W(WW), .TIMEOUT(TMO), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .wb(wb_bus), .ex(ex_bus), .ext(ext_bus),
    .owner(owner), .busy(busy), .timeout_evt(timeout_evt)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: phase 0 = no transaction, 1 = a master holds the bus, 2 = cooldown after completion.
  int m_phase = 0;
  bit m_own   = 1'b0;
  int m_wait  = 0;

  always @(negedge clk) begin
    bit g, rv, rsp, tmo, fwd;
    logic [AW-1:0] ea;
    logic          erw;
    logic [WW-1:0] ewd;
    logic [DW-1:0] ewr;
    if (chk_on) begin
      g   = (m_phase == 1);
      rv  = g && (m_own ? wb_bus.taskValid : ex_bus.taskValid);
      rsp = rv && (ext_bus.taskReady || ext_bus.taskError);
      tmo = rv && !rsp && (m_wait == TMO - 1);
      fwd = rv && !tmo;
      ea  = !g ? '0 : (m_own ? wb_bus.address  : ex_bus.address);
      erw = !g ? 1'b0 : (m_own ? wb_bus.rwCtrl : ex_bus.rwCtrl);
      ewd = !g ? '0 : (m_own ? wb_bus.widthCtr : ex_bus.widthCtr);
      ewr = !g ? '0 : (m_own ? wb_bus.writeBus : ex_bus.writeBus);
      chk("m_ext_valid", ext_bus.taskValid, fwd);
      chk("m_ext_addr",  ext_bus.address, ea);
      chk("m_ext_rw",    ext_bus.rwCtrl, erw);
      chk("m_ext_wid",   ext_bus.widthCtr, ewd);
      chk("m_ext_wdata", ext_bus.writeBus, ewr);
      chk("m_wb_ready",  wb_bus.taskReady, m_own && rsp && ext_bus.taskReady);
      chk("m_wb_error",  wb_bus.taskError, m_own && ((rsp && ext_bus.taskError) || tmo));
      chk("m_wb_rdata",  wb_bus.readBus, (m_own && fwd) ? ext_bus.readBus : '0);
      chk("m_ex_ready",  ex_bus.taskReady, !m_own && rsp && ext_bus.taskReady);
      chk("m_ex_error",  ex_bus.taskError, !m_own && ((rsp && ext_bus.taskError) || tmo));
      chk("m_ex_rdata",  ex_bus.readBus, (!m_own && fwd) ? ext_bus.readBus : '0);
      chk("m_busy",      busy, g);
      chk("m_tmo_evt",   timeout_evt, tmo);
      chk("m_owner",     owner, m_own);
    end
  end

  always @(posedge clk) begin
    bit rv, rsp, tmo;
    rv  = (m_phase == 1) && (m_own ? wb_bus.taskValid : ex_bus.taskValid);
    rsp = rv && (ext_bus.taskReady || ext_bus.taskError);
    tmo = rv && !rsp && (m_wait == TMO - 1);
    if (rst) begin
      m_phase <= 0;
      m_own   <= 1'b0;
      m_wait  <= 0;
    end else if (m_phase == 0) begin
      if (wb_bus.taskValid) begin
        m_phase <= 1; m_own <= 1'b1; m_wait <= 0;
      end else if (ex_bus.taskValid) begin
        m_phase <= 1; m_own <= 1'b0; m_wait <= 0;
      end
    end else if (m_phase == 1) begin
      if (!rv)             m_phase <= 0;
      else if (rsp || tmo) m_phase <= 2;
      else                 m_wait  <= m_wait + 1;
    end else begin
      m_phase <= 0;
    end
  end

  // Applies one cycle of inputs just after the edge and returns mid-cycle for checking.
  task automatic cyc(input bit r, input bit wv, input logic [31:0] wa,
                     input bit ev, input logic [31:0] ea,
                     input bit rdy, input bit err, input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst               = r;
    wb_bus.taskValid  = wv;
    wb_bus.address    = wa;
    ex_bus.taskValid  = ev;
    ex_bus.address    = ea;
    ext_bus.taskReady = rdy;
    ext_bus.taskError = err;
    ext_bus.readBus   = rd;
    @(negedge clk);
  endtask

  initial begin
    wb_bus.rwCtrl = 1'b0; wb_bus.widthCtr = 2'd2; wb_bus.writeBus = 32'h1111_1111;
    ex_bus.rwCtrl = 1'b1; ex_bus.widthCtr = 2'd1; ex_bus.writeBus = 32'h2222_2222;
    wb_bus.taskValid = 1'b0; wb_bus.address = '0;
    ex_bus.taskValid = 1'b0; ex_bus.address = '0;
    ext_bus.taskReady = 1'b0; ext_bus.taskError = 1'b0; ext_bus.readBus = '0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk_on = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ext_valid", ext_bus.taskValid, 0);

    // Single EX read, bus answers two cycles after the request appears.
    cyc(0, 0, 0, 1, 32'h1000, 0, 0, 0);
    chk("t1_idle_valid", ext_bus.taskValid, 0);
    cyc(0, 0, 0, 1, 32'h1000, 0, 0, 0);
    chk("t1_fwd_valid", ext_bus.taskValid, 1);
    chk("t1_fwd_addr", ext_bus.address, 32'h1000);
    cyc(0, 0, 0, 1, 32'h1000, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h1000, 1, 0, 32'hDEAD_BEEF);
    chk("t1_ex_ready", ex_bus.taskReady, 1);
    chk("t1_ex_rdata", ex_bus.readBus, 32'hDEAD_BEEF);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_cool_busy", busy, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_owner", owner, 0);

    // Simultaneous requests: WB first, EX reaches the bus after cooldown and idle.
    cyc(0, 1, 32'h4, 1, 32'h2000, 0, 0, 0);
    cyc(0, 1, 32'h4, 1, 32'h2000, 1, 0, 32'hA5A5_A5A5);
    chk("t2_owner_wb", owner, 1);
    chk("t2_wb_addr", ext_bus.address, 32'h4);
    chk("t2_wb_ready", wb_bus.taskReady, 1);
    chk("t2_ex_stall", ex_bus.taskReady, 0);
    cyc(0, 0, 0, 1, 32'h2000, 0, 0, 0);
    chk("t2_gap1_valid", ext_bus.taskValid, 0);
    cyc(0, 0, 0, 1, 32'h2000, 0, 0, 0);
    chk("t2_gap2_valid", ext_bus.taskValid, 0);
    cyc(0, 0, 0, 1, 32'h2000, 1, 0, 32'h1234_5678);
    chk("t2_ex_addr", ext_bus.address, 32'h2000);
    chk("t2_ex_rdata", ex_bus.readBus, 32'h1234_5678);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // WB arrives during an EX transaction and must not preempt it.
    cyc(0, 0, 0, 1, 32'h3000, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h3000, 0, 0, 0);
    cyc(0, 1, 32'h8, 1, 32'h3000, 0, 0, 0);
    chk("t3_owner_ex", owner, 0);
    chk("t3_ex_addr", ext_bus.address, 32'h3000);
    cyc(0, 1, 32'h8, 1, 32'h3000, 1, 0, 32'hCAFE_F00D);
    chk("t3_ex_ready", ex_bus.taskReady, 1);
    chk("t3_wb_stall", wb_bus.taskReady, 0);
    cyc(0, 1, 32'h8, 0, 0, 0, 0, 0);
    chk("t3_cool_valid", ext_bus.taskValid, 0);
    cyc(0, 1, 32'h8, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h8, 0, 0, 1, 0, 0);
    chk("t3_owner_wb", owner, 1);
    chk("t3_wb_addr", ext_bus.address, 32'h8);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Watchdog fires in the fourth silent granted cycle.
    cyc(0, 0, 0, 1, 32'h4000, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 32'h4000, 0, 0, 0);
    chk("t4_pre_evt", timeout_evt, 0);
    cyc(0, 0, 0, 1, 32'h4000, 0, 0, 32'h5555_5555);
    chk("t4_ex_error", ex_bus.taskError, 1);
    chk("t4_ex_ready", ex_bus.taskReady, 0);
    chk("t4_ex_rdata", ex_bus.readBus, 0);
    chk("t4_evt", timeout_evt, 1);
    chk("t4_ext_valid", ext_bus.taskValid, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_cool_busy", busy, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // A real response in the watchdog cycle wins.
    cyc(0, 0, 0, 1, 32'h4100, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 32'h4100, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h4100, 1, 0, 32'h0BAD_F00D);
    chk("t4b_ex_ready", ex_bus.taskReady, 1);
    chk("t4b_ex_error", ex_bus.taskError, 0);
    chk("t4b_evt", timeout_evt, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Ready and error together are both passed through.
    cyc(0, 1, 32'h10, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h10, 0, 0, 1, 1, 32'h7777_0000);
    chk("t6_wb_ready", wb_bus.taskReady, 1);
    chk("t6_wb_error", wb_bus.taskError, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // WB abandons its request in the second granted cycle.
    cyc(0, 1, 32'hC, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hC, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_abort_valid", ext_bus.taskValid, 0);
    chk("t5_abort_ready", wb_bus.taskReady, 0);
    chk("t5_abort_error", wb_bus.taskError, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_abort_busy", busy, 0);

    // Reset in the middle of a WB grant.
    cyc(0, 1, 32'h20, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h20, 0, 0, 0, 0, 0);
    chk("t7_busy_pre", busy, 1);
    chk("t7_owner_pre", owner, 1);
    cyc(1, 1, 32'h20, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t7_busy", busy, 0);
    chk("t7_ext_valid", ext_bus.taskValid, 0);
    chk("t7_owner", owner, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
